// File: rtl/seq_norm_round_if.sv
// Handshake and data bundle between the normalise/round stage and its producer.
interface seq_norm_round_if #(
    parameter int EXPW = 10
);
    logic            start;
    logic [47:0]     prod_in;
    logic [EXPW-1:0] exp_in;
    logic [23:0]     mant_out;
    logic [EXPW-1:0] exp_out;
    logic            zero;
    logic            done;
    logic            ready;

    modport master (
        output start, prod_in, exp_in,
        input  mant_out, exp_out, zero, done, ready
    );

    modport slave (
        input  start, prod_in, exp_in,
        output mant_out, exp_out, zero, done, ready
    );
endinterface

// File: rtl/seq_norm_round.sv
// Sequential normalise-and-round stage: one-bit-per-cycle left shift, then round to 24 bits.
// Define NORM_RNE_ROUND_EN for round-to-nearest-even; the default build truncates.
module seq_norm_round #(
    parameter int EXPW = 10
) (
    input  logic              clk,
    input  logic              rst,
    seq_norm_round_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] ROUND = 2'd3;

    localparam logic [EXPW-1:0] EXP_ONE = EXPW'(1);

    logic [1:0]      state_q,   state_d;
    logic [47:0]     p_q,       p_d;
    logic [EXPW-1:0] e_q,       e_d;
    logic [23:0]     mantOut_q, mantOut_d;
    logic [EXPW-1:0] expOut_q,  expOut_d;
    logic            zero_q,    zero_d;
    logic            done_q,    done_d;

    logic [23:0]     roundMant;
    logic [EXPW-1:0] roundExp;

    // A carry out of an all-ones mantissa renormalises to 1.0 with the exponent bumped.
    always_comb begin
        roundMant = p_q[47:24];
        roundExp  = e_q;
`ifdef NORM_RNE_ROUND_EN
        if (p_q[23] & ((|p_q[22:0]) | p_q[24])) begin
            if (&p_q[47:24]) begin
                roundMant = 24'h800000;
                roundExp  = e_q + EXP_ONE;
            end else begin
                roundMant = p_q[47:24] + 24'd1;
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        e_d       = e_q;
        mantOut_d = mantOut_q;
        expOut_d  = expOut_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    p_d     = bus.prod_in;
                    e_d     = bus.exp_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (p_q == 48'd0) begin
                    mantOut_d = 24'd0;
                    expOut_d  = '0;
                    zero_d    = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    // Moving the binary point from bit 46 to bit 47 adds one to the exponent.
                    e_d     = e_q + EXP_ONE;
                    state_d = p_q[47] ? ROUND : SHIFT;
                end
            end
            SHIFT: begin
                p_d = {p_q[46:0], 1'b0};
                e_d = e_q - EXP_ONE;
                if (p_q[46]) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                mantOut_d = roundMant;
                expOut_d  = roundExp;
                zero_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            p_q       <= 48'd0;
            e_q       <= '0;
            mantOut_q <= 24'd0;
            expOut_q  <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            e_q       <= e_d;
            mantOut_q <= mantOut_d;
            expOut_q  <= expOut_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
        end
    end

    assign bus.mant_out = mantOut_q;
    assign bus.exp_out  = expOut_q;
    assign bus.zero     = zero_q;
    assign bus.done     = done_q;
    assign bus.ready    = (state_q == IDLE);
endmodule

// File: tb/tb_seq_norm_round.sv
// Scoreboard bench for seq_norm_round: stimulus pushes reference results, a monitor pops them on done.
// Honours NORM_RNE_ROUND_EN the same way the design does.
module tb_seq_norm_round;
    localparam int EXPW = 10;

    typedef struct {
        logic [23:0]     mant;
        logic [EXPW-1:0] ex;
        logic            z;
        longint          doneCycle;
    } expect_t;

    logic   clk;
    logic   rst;
    longint cycleCount;
    int     checks;
    int     errors;
    expect_t sbQ[$];

    seq_norm_round_if #(.EXPW(EXPW)) bus ();

    seq_norm_round #(.EXPW(EXPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycleCount);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out at cycle %0d", name, cycleCount);
    endtask

    // Reference: normalise by counting leading zeros, then round on the discarded remainder.
    function automatic void model(input logic [47:0] prod, input logic [EXPW-1:0] ein,
                                  output expect_t x, output int lat);
        int          k;
        int          ev;
        longint      mantInt;
        longint      rem;
        logic [47:0] norm;
        if (prod == 48'd0) begin
            x.mant = 24'd0;
            x.ex   = '0;
            x.z    = 1'b1;
            lat    = 1;
            return;
        end
        k = 0;
        while (prod[47-k] == 1'b0) k++;
        norm    = prod << k;
        mantInt = longint'(norm >> 24);
        rem     = longint'(norm & 48'hFFFFFF);
        ev      = int'($signed(ein)) + 1 - k;
`ifdef NORM_RNE_ROUND_EN
        if (rem > 64'h800000 || (rem == 64'h800000 && (mantInt % 2) == 1)) mantInt++;
        if (mantInt == (64'd1 << 24)) begin
            mantInt = 64'd1 << 23;
            ev++;
        end
`else
        if (rem < 0) mantInt = 0;
`endif
        x.mant = mantInt[23:0];
        x.ex   = ev[EXPW-1:0];
        x.z    = 1'b0;
        lat    = k + 2;
    endfunction

    // Called on a negedge; waits for ready, raises start for exactly one clock edge.
    task automatic applyStimulus(input logic [47:0] prod, input logic [EXPW-1:0] ein);
        expect_t x;
        int      lat;
        int      t;
        t = 0;
        while (!bus.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.ready) begin
            reportTimeout("wait_ready");
            return;
        end
        model(prod, ein, x, lat);
        x.doneCycle = cycleCount + 1 + lat;
        sbQ.push_back(x);
        bus.start   = 1'b1;
        bus.prod_in = prod;
        bus.exp_in  = ein;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(bus.ready && sbQ.size() == 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!(bus.ready && sbQ.size() == 0)) reportTimeout("wait_idle");
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, on its exact cycle.
    always @(negedge clk) begin
        expect_t x;
        if (!rst && bus.done) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cycleCount);
            end else begin
                x = sbQ.pop_front();
                checkOutput("mant_out", 64'(bus.mant_out), 64'(x.mant));
                checkOutput("exp_out", 64'(bus.exp_out), 64'(x.ex));
                checkOutput("zero", 64'(bus.zero), 64'(x.z));
                checkOutput("ready_with_done", 64'(bus.ready), 64'd1);
                checkOutput("done_cycle", 64'(cycleCount), 64'(x.doneCycle));
            end
        end
    end

    initial begin
        logic [EXPW-1:0] expv;
        logic [47:0]     prod;
        cycleCount  = 0;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.prod_in = 48'd0;
        bus.exp_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_mant", 64'(bus.mant_out), 64'd0);
        checkOutput("reset_exp", 64'(bus.exp_out), 64'd0);
        checkOutput("reset_zero", 64'(bus.zero), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_ready", 64'(bus.ready), 64'd1);

        applyStimulus(48'h4, 10'd0);
        waitIdle();
        expv = EXPW'(-44);
        checkOutput("case1_mant", 64'(bus.mant_out), 64'h800000);
        checkOutput("case1_exp", 64'(bus.exp_out), 64'(expv));

        applyStimulus(48'h400000000000, 10'd5);
        applyStimulus(48'hC00000000000, 10'd3);
        waitIdle();
        checkOutput("case2_mant", 64'(bus.mant_out), 64'hC00000);
        checkOutput("case2_exp", 64'(bus.exp_out), 64'd4);

        applyStimulus(48'hFFFFFF800000, 10'd0);
        waitIdle();
`ifdef NORM_RNE_ROUND_EN
        checkOutput("case3_mant", 64'(bus.mant_out), 64'h800000);
        checkOutput("case3_exp", 64'(bus.exp_out), 64'd2);
`else
        checkOutput("case3_mant", 64'(bus.mant_out), 64'hFFFFFF);
        checkOutput("case3_exp", 64'(bus.exp_out), 64'd1);
`endif
        applyStimulus(48'h800000800000, 10'd0);
        waitIdle();
        checkOutput("case3_tie_mant", 64'(bus.mant_out), 64'h800000);

        applyStimulus(48'h0, 10'd7);
        waitIdle();
        checkOutput("case4_zero", 64'(bus.zero), 64'd1);
        applyStimulus(48'h123456789ABC, 10'd7);
        waitIdle();
        checkOutput("case4_zero_cleared", 64'(bus.zero), 64'd0);

        // A start while busy must be dropped entirely.
        applyStimulus(48'h1, 10'd20);
        repeat (5) @(negedge clk);
        checkOutput("case6_busy", 64'(bus.ready), 64'd0);
        bus.start   = 1'b1;
        bus.prod_in = 48'hC00000000000;
        bus.exp_in  = 10'd3;
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle();
        expv = EXPW'(20 - 46);
        checkOutput("case6_mant", 64'(bus.mant_out), 64'h800000);
        checkOutput("case6_exp", 64'(bus.exp_out), 64'(expv));

        // Abort mid-shift; the aborted operation must never report.
        applyStimulus(48'h1, 10'd0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sbQ.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("case5_mant", 64'(bus.mant_out), 64'd0);
        checkOutput("case5_exp", 64'(bus.exp_out), 64'd0);
        checkOutput("case5_zero", 64'(bus.zero), 64'd0);
        checkOutput("case5_done", 64'(bus.done), 64'd0);
        checkOutput("case5_ready", 64'(bus.ready), 64'd1);
        repeat (60) @(negedge clk);
        applyStimulus(48'h000000F00000, 10'd100);
        waitIdle();

        for (int i = 0; i < 60; i++) begin
            prod = {$urandom(), $urandom()} >> 16;
            prod = prod >> $urandom_range(0, 47);
            if ($urandom_range(0, 7) == 0) prod = 48'd0;
            if ($urandom_range(0, 5) == 0) prod = {24'hFFFFFF, 1'b1, 23'($urandom())};
            applyStimulus(prod, EXPW'($urandom()));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
